// File: rtl/mem_access_unit.sv
// Load/store front-end for the MEM stage: turns byte-addressed MIPS accesses into
// word-indexed data-memory accesses, with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              dm_we,
  output logic [31:0]       dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              misalign,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e              state_q, state_d;
  logic [31:0]         merge_q, merge_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ld_valid_q, ld_valid_d;
  logic [31:0]         ld_data_q, ld_data_d;
  logic                misalign_q, misalign_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic                stall_c, dm_we_c;
  logic                is_word, is_half, mis;
  logic [ADDR_W-1:0]   req_idx;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [31:0]         merged;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  always_comb begin
    is_word = req_size[1];
    is_half = (req_size == 2'b01);
    mis     = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    req_idx = req_addr[ADDR_W+1:2];

    case (req_addr[1:0])
      2'd0:    lane_b = dm_rdata[7:0];
      2'd1:    lane_b = dm_rdata[15:8];
      2'd2:    lane_b = dm_rdata[23:16];
      default: lane_b = dm_rdata[31:24];
    endcase
    lane_h = req_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    merged = dm_rdata;
    if (is_half) begin
      if (req_addr[1]) merged[31:16] = req_wdata[15:0];
      else             merged[15:0]  = req_wdata[15:0];
    end else begin
      case (req_addr[1:0])
        2'd0:    merged[7:0]   = req_wdata[7:0];
        2'd1:    merged[15:8]  = req_wdata[7:0];
        2'd2:    merged[23:16] = req_wdata[7:0];
        default: merged[31:24] = req_wdata[7:0];
      endcase
    end

    state_d    = state_q;
    merge_d    = merge_q;
    addr_d     = addr_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    misalign_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    stall_c    = 1'b0;
    dm_we_c    = 1'b0;
    dm_addr    = {{(32-ADDR_W){1'b0}}, req_idx};
    dm_wdata   = req_wdata;

    case (state_q)
      WRITE: begin
        dm_we_c  = 1'b1;
        dm_addr  = {{(32-ADDR_W){1'b0}}, addr_q};
        dm_wdata = merge_q;
        state_d  = IDLE;
      end
      default: begin
        if (req_valid) begin
          if (mis) begin
            misalign_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          end else if (!req_we) begin
            ld_valid_d = 1'b1;
            if (is_word)      ld_data_d = dm_rdata;
            else if (is_half) ld_data_d = {{16{req_sign & lane_h[15]}}, lane_h};
            else              ld_data_d = {{24{req_sign & lane_b[7]}}, lane_b};
          end else if (is_word) begin
            dm_we_c = 1'b1;
          end else begin
            // Sub-word store: capture the merged word now, write it next cycle.
            stall_c = 1'b1;
            merge_d = merged;
            addr_d  = req_idx;
            state_d = WRITE;
          end
        end
      end
    endcase
  end

  // Gated by reset so an in-flight write is abandoned the instant reset asserts.
  assign stall = stall_c & reset;
  assign dm_we = dm_we_c & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      merge_q    <= '0;
      addr_q     <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      merge_q    <= merge_d;
      addr_q     <= addr_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;
  assign misalign = misalign_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: byte-level memory model plus per-cycle compare.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, dm_we, ld_valid, misalign;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, ld_data;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  mem_access_unit #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .ld_valid(ld_valid),
    .ld_data(ld_data), .misalign(misalign), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Data memory: 256 x 32, combinational read, synchronous write.
  logic [31:0] mem [256];
  assign dm_rdata = mem[dm_addr[7:0]];
  always @(posedge clk) if (dm_we) mem[dm_addr[7:0]] <= dm_wdata;

  // Reference model state
  logic [31:0] ref_mem [256];
  logic        wr_pending = 1'b0;
  logic [7:0]  wr_idx = '0;
  logic [31:0] wr_word = '0;
  logic        exp_stall = 1'b0, exp_we = 1'b0, exp_ldv = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_addr = '0, exp_wd = '0, exp_ldd = '0;
  logic [7:0]  exp_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",    {31'd0, stall},    {31'd0, exp_stall});
      chk("dm_we",    {31'd0, dm_we},    {31'd0, exp_we});
      chk("dm_addr",  dm_addr,           exp_addr);
      if (exp_we) chk("dm_wdata", dm_wdata, exp_wd);
      chk("ld_valid", {31'd0, ld_valid}, {31'd0, exp_ldv});
      if (exp_ldv) chk("ld_data", ld_data, exp_ldd);
      chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
      chk("err_cnt",  {24'd0, err_cnt},  {24'd0, exp_cnt});
    end
  end

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [31:0] a);
    logic [31:0] sh;
    int n;
    n  = size_bytes(sz);
    sh = w >> (8 * a[1:0]);
    if (n == 4) return w;
    if (n == 2) begin
      sh = sh & 32'h0000FFFF;
      if (sg && sh[15]) sh = sh | 32'hFFFF0000;
    end else begin
      sh = sh & 32'h000000FF;
      if (sg && sh[7]) sh = sh | 32'hFFFFFF00;
    end
    return sh;
  endfunction

  // Drives one cycle starting at posedge+1, ends at the next posedge+1.
  task automatic step(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd);
    logic [7:0]  idx;
    logic [31:0] mask, n_ldd;
    logic        n_ldv, n_mis, do_word, do_pend;
    logic [7:0]  n_cnt;
    int          n;
    idx = a[9:2];
    n = size_bytes(sz);
    req_valid = v; req_we = we; req_size = sz; req_sign = sg; req_addr = a; req_wdata = wd;
    n_ldv = 1'b0; n_mis = 1'b0; n_ldd = exp_ldd; n_cnt = exp_cnt;
    do_word = 1'b0; do_pend = 1'b0; mask = '0;
    exp_stall = 1'b0; exp_we = 1'b0; exp_wd = wd; exp_addr = {24'd0, idx};
    if (wr_pending) begin
      exp_we = 1'b1; exp_addr = {24'd0, wr_idx}; exp_wd = wr_word;
    end else if (v) begin
      if ((a % n) != 0) begin
        n_mis = 1'b1;
        n_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
      end else if (!we) begin
        n_ldv = 1'b1;
        n_ldd = load_val(ref_mem[idx], sz, sg, a);
      end else if (n == 4) begin
        exp_we = 1'b1; do_word = 1'b1;
      end else begin
        exp_stall = 1'b1; do_pend = 1'b1;
        mask = ((n == 1) ? 32'h000000FF : 32'h0000FFFF) << (8 * a[1:0]);
      end
    end
    @(posedge clk); #1;
    if (wr_pending) begin
      ref_mem[wr_idx] = wr_word;
      wr_pending = 1'b0;
    end else if (do_word) begin
      ref_mem[idx] = wd;
    end else if (do_pend) begin
      wr_pending = 1'b1;
      wr_idx = idx;
      wr_word = (ref_mem[idx] & ~mask) | ((wd << (8 * a[1:0])) & mask);
    end
    exp_ldv = n_ldv; exp_ldd = n_ldd; exp_mis = n_mis; exp_cnt = n_cnt;
  endtask

  task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    step(1'b1, 1'b0, sz, sg, a, 32'h0);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    step(1'b1, 1'b1, sz, 1'b0, a, wd);
    if (wr_pending) step(1'b1, 1'b1, sz, 1'b0, a, wd);
  endtask

  task automatic idle(input logic [31:0] a);
    step(1'b0, 1'b0, 2'b00, 1'b0, a, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
    chk("rst_ld_data",  ld_data, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_err_cnt",  {24'd0, err_cnt}, 32'd0);
    chk("rst_stall",    {31'd0, stall}, 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;

    // Word store then load
    st(2'b10, 32'h10, 32'hDEADBEEF);
    ld(2'b10, 1'b0, 32'h10);
    chk("lw_lit", ld_data, 32'hDEADBEEF);
    idle(32'h44);
    chk("ldv_one_cycle", {31'd0, ld_valid}, 32'd0);

    // Byte store RMW with explicit pins on the WRITE cycle
    step(1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5);
    chk("sb_we_lit", {31'd0, dm_we}, 32'd1);
    chk("sb_wdata_lit", dm_wdata, 32'hDEADA5EF);
    chk("sb_addr_lit", dm_addr, 32'd4);
    step(1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5);
    ld(2'b00, 1'b1, 32'h11);
    chk("lb_lit", ld_data, 32'hFFFFFFA5);
    ld(2'b00, 1'b0, 32'h11);
    chk("lbu_lit", ld_data, 32'h000000A5);

    // Half store and loads
    st(2'b01, 32'h12, 32'hFFFF1234);
    ld(2'b01, 1'b0, 32'h12);
    chk("lh_hi_lit", ld_data, 32'h00001234);
    ld(2'b01, 1'b1, 32'h10);
    chk("lh_lo_lit", ld_data, 32'hFFFFA5EF);
    ld(2'b10, 1'b0, 32'h10);
    chk("lw_merged_lit", ld_data, 32'h1234A5EF);

    // Misaligned word load
    ld(2'b10, 1'b0, 32'h13);
    chk("mis_lit", {31'd0, misalign}, 32'd1);
    chk("mis_cnt_lit", {24'd0, err_cnt}, 32'd1);
    chk("mis_noload_lit", {31'd0, ld_valid}, 32'd0);

    // Sub-word store immediately followed by load of same word
    st(2'b10, 32'h20, 32'hCAFEF00D);
    st(2'b00, 32'h22, 32'h00000077);
    ld(2'b10, 1'b0, 32'h20);
    chk("sb_then_lw_lit", ld_data, 32'hCA77F00D);

    // Every lane of byte and half, size 11 treated as word, misaligned stores
    st(2'b11, 32'h40, 32'h89ABCDEF);
    for (int i = 0; i < 4; i++) begin
      ld(2'b00, 1'b1, 32'h40 + i);
      ld(2'b00, 1'b0, 32'h40 + i);
    end
    ld(2'b11, 1'b0, 32'h40);
    ld(2'b01, 1'b1, 32'h42);
    ld(2'b01, 1'b0, 32'h40);
    for (int i = 0; i < 4; i++) st(2'b00, 32'h44 + i, 32'h10 * (i + 1));
    ld(2'b10, 1'b0, 32'h44);
    chk("bytes_lit", ld_data, 32'h40302010);
    st(2'b01, 32'h45, 32'h0000BEEF);
    st(2'b10, 32'h46, 32'h00000000);
    st(2'b11, 32'h41, 32'h00000000);
    ld(2'b10, 1'b0, 32'h44);
    chk("mis_store_nowrite_lit", ld_data, 32'h40302010);
    idle(32'h3FC);

    // Counter saturation
    for (int i = 0; i < 300; i++) ld((i % 2 == 0) ? 2'b10 : 2'b01, 1'b0, 32'h101 + 2 * i);
    chk("sat_lit", {24'd0, err_cnt}, 32'd255);

    // Reset asserted during the WRITE cycle
    st(2'b10, 32'h30, 32'h13572468);
    step(1'b1, 1'b1, 2'b00, 1'b0, 32'h31, 32'h000000EE);
    chk_en = 1'b0;
    chk("pre_rst_we", {31'd0, dm_we}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_we_drop", {31'd0, dm_we}, 32'd0);
    chk("rst_stall_drop", {31'd0, stall}, 32'd0);
    chk("rst_err_cnt2", {24'd0, err_cnt}, 32'd0);
    chk("rst_ld_data2", ld_data, 32'd0);
    chk("rst_ldv2", {31'd0, ld_valid}, 32'd0);
    chk("rst_mis2", {31'd0, misalign}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    wr_pending = 1'b0;
    exp_ldv = 1'b0; exp_ldd = '0; exp_mis = 1'b0; exp_cnt = '0;
    chk("rst_mem_unchanged", mem[12], 32'h13572468);
    chk_en = 1'b1;
    idle(32'h30);
    ld(2'b10, 1'b0, 32'h30);
    chk("post_rst_lw_lit", ld_data, 32'h13572468);
    idle(32'h0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front-end for the MEM stage, placed directly upstream of the word-addressed data memory (256 x 32, combinational read, synchronous write). It converts byte-addressed MIPS accesses of byte, halfword or word size into word-indexed memory accesses. Sub-word stores are done as a two-cycle read-modify-write. Load data is aligned and sign/zero-extended into a registered result, and misaligned accesses are detected and counted.

Parameters:
ADDR_W, 8, word-index width driven to the data memory (2^ADDR_W words)
CNT_W, 8, width of the saturating misaligned-access counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  access request this cycle
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
req_sign  in  1  loads: 1 sign-extend, 0 zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
stall  out  1  upstream must hold request and pipeline
dm_we  out  1  data-memory write enable
dm_addr  out  32  word index, zero-extended {0, req_addr[ADDR_W+1:2]}
dm_wdata  out  32  data-memory write data
dm_rdata  in  32  data-memory combinational read data
ld_valid  out  1  one-cycle pulse, ld_data valid
ld_data  out  32  aligned, extended load result
misalign  out  1  one-cycle pulse after a misaligned request
err_cnt  out  CNT_W  saturating count of misaligned requests

Behaviour:
- Lane order is little-endian: byte lane = addr[1:0], lane 0 = bits 7:0; half lane = addr[1], 0 = bits 15:0.
- Misaligned condition: half with addr[0]=1, or word with addr[1:0]!=0. Misaligned requests cause no memory write and no ld_valid. On the next edge: misalign<=1 for one cycle, err_cnt increments, saturating at 2^CNT_W-1. stall=0.
- FSM states: IDLE, WRITE.
- IDLE, aligned load: dm_addr from req_addr, dm_we=0. On the next edge, ld_data<=extracted lane (extended per req_sign), and ld_valid<=1 for exactly one cycle. stall=0.
- IDLE, aligned word store: dm_we=1, dm_wdata=req_wdata in the same cycle; the write commits at that edge. stall=0.
- IDLE, aligned byte/half store: dm_we=0, stall=1 (combinational). On the edge, merge_reg<=dm_rdata with the target lane replaced by req_wdata[7:0]/[15:0], addr_reg<=word index, then go to WRITE.
- WRITE: dm_we=1, dm_addr=addr_reg, dm_wdata=merge_reg, stall=0. Request inputs are ignored this cycle; upstream still presents the same store and advances at this edge. Next state is IDLE.
- req_valid=0 in IDLE: dm_we=0, stall=0, no pulses; dm_addr still follows req_addr.
- Reset (asynchronous, active-low) forces state IDLE and clears ld_valid, ld_data, misalign, err_cnt, merge_reg and addr_reg to 0. dm_we and stall drop immediately. Reset during WRITE abandons the write; memory is unchanged.
- A load issued the cycle after WRITE observes the merged word. No forwarding is required because the write commits before the load's read.
- Latency: loads 1 cycle; word stores 0 extra cycles; sub-word stores 1 stall cycle.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> dm_we=1 one cycle with dm_addr=4; next load gives ld_data=0xDEADBEEF, ld_valid high for exactly 1 cycle.
- sb 0xA5 @0x11 over 0xDEADBEEF -> stall=1 for 1 cycle, then dm_we=1, dm_wdata=0xDEADA5EF; lb @0x11 -> 0xFFFFFFA5; lbu @0x11 -> 0x000000A5.
- sh 0x1234 @0x12 -> word becomes 0x1234A5EF; lh @0x12 -> 0x00001234; lh @0x10 with sign -> 0xFFFFA5EF.
- lw @0x13 -> no dm_we, no ld_valid, misalign pulse, err_cnt=1; 300 misaligned requests -> err_cnt=255 (saturated).
- sb @0x20 immediately followed by lw @0x20 -> lw returns the merged word; no stale data.
- Assert reset low during the WRITE cycle -> dm_we drops immediately, memory word unchanged, all outputs 0, state IDLE after release.
